// File: rtl/turn_phase_timer.sv
// Battle turn sequencer: a timed DODGE phase, a MENU phase that waits for an attack
// (with an optional timeout), and an OVER phase that records who won.
module turn_phase_timer #(
    parameter int          DODGE_CYCLES = 125000000,
    parameter int          MENU_CYCLES  = 0,
    parameter int          CNT_W        = 27,
    parameter int          ROUND_W      = 8,
    parameter logic [2:0]  START_SCENE  = 3'b100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [2:0]         i_scene,
    input  logic               i_attack,
    input  logic               i_character_alive,
    input  logic               i_monster_alive,
    input  logic               i_pause,
    output logic [1:0]         o_state_game,
    output logic [CNT_W-1:0]   o_time_left,
    output logic [ROUND_W-1:0] o_round,
    output logic               o_phase_pulse,
    output logic [1:0]         o_result
);

    typedef enum logic [1:0] {
        DODGE = 2'd0,
        MENU  = 2'd1,
        OVER  = 2'd2
    } phase_t;

    localparam logic [1:0] RESULT_NONE = 2'b00;
    localparam logic [1:0] RESULT_WON  = 2'b01;
    localparam logic [1:0] RESULT_LOST = 2'b10;

    localparam logic [CNT_W-1:0] DODGE_LOAD = CNT_W'(DODGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MENU_LOAD  =
        (MENU_CYCLES != 0) ? CNT_W'(MENU_CYCLES - 1) : '0;
    localparam logic MENU_TIMED = (MENU_CYCLES != 0);

    phase_t             state, state_next;
    logic [CNT_W-1:0]   time_left, time_next;
    logic [ROUND_W-1:0] round, round_next;
    logic [1:0]         result, result_next;
    logic               pulse;

    logic both_alive;
    assign both_alive = i_character_alive && i_monster_alive;

    // NOTE: every output is assigned a default first, so no path through the
    // case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        time_next   = time_left;
        round_next  = round;
        result_next = result;

        unique case (state)
            DODGE, MENU: begin
                if (!both_alive) begin
                    state_next  = OVER;
                    result_next = i_character_alive ? RESULT_WON : RESULT_LOST;
                end else if (!i_pause) begin
                    if (state == DODGE) begin
                        if (time_left == '0) begin
                            state_next = MENU;
                            time_next  = MENU_LOAD;
                        end else begin
                            time_next = time_left - 1'b1;
                        end
                    end else if (i_attack || (MENU_TIMED && time_left == '0)) begin
                        // An expired menu timer forfeits the turn just like an attack ends it.
                        state_next = DODGE;
                        time_next  = DODGE_LOAD;
                        if (round != '1) begin
                            round_next = round + 1'b1;
                        end
                    end else if (MENU_TIMED) begin
                        time_next = time_left - 1'b1;
                    end
                end
            end
            default: begin
                if (i_scene == START_SCENE && both_alive) begin
                    state_next  = DODGE;
                    time_next   = DODGE_LOAD;
                    round_next  = '0;
                    result_next = RESULT_NONE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= OVER;
            time_left <= '0;
            round     <= '0;
            result    <= RESULT_NONE;
            pulse     <= 1'b0;
        end else begin
            state     <= state_next;
            time_left <= time_next;
            round     <= round_next;
            result    <= result_next;
            pulse     <= (state_next != state);
        end
    end

    assign o_state_game  = state;
    assign o_time_left   = time_left;
    assign o_round       = round;
    assign o_result      = result;
    assign o_phase_pulse = pulse;

endmodule

// File: tb/tb_turn_phase_timer.sv
// Directed-vector bench for turn_phase_timer with a short dodge phase and a
// five-cycle menu timeout so every phase boundary is reached quickly.
module tb_turn_phase_timer;

    localparam int CNT_W   = 4;
    localparam int ROUND_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         scene;
    logic               attack;
    logic               char_alive;
    logic               mon_alive;
    logic               pause;
    logic [1:0]         state;
    logic [CNT_W-1:0]   time_left;
    logic [ROUND_W-1:0] round;
    logic               pulse;
    logic [1:0]         result;

    int vectors     = 0;
    int miscompares = 0;

    turn_phase_timer #(
        .DODGE_CYCLES(8),
        .MENU_CYCLES (5),
        .CNT_W       (CNT_W),
        .ROUND_W     (ROUND_W),
        .START_SCENE (3'b100)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_scene          (scene),
        .i_attack         (attack),
        .i_character_alive(char_alive),
        .i_monster_alive  (mon_alive),
        .i_pause          (pause),
        .o_state_game     (state),
        .o_time_left      (time_left),
        .o_round          (round),
        .o_phase_pulse    (pulse),
        .o_result         (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int target, input string tag);
        int n = 0;
        while (state != 2'(target) && n < 40) begin
            step();
            n++;
        end
        check(tag, int'(state), target);
    endtask

    task automatic check_all(input string tag, input int s, input int t,
                             input int r, input int p, input int res);
        check({tag, ".state"}, int'(state), s);
        check({tag, ".time"}, int'(time_left), t);
        check({tag, ".round"}, int'(round), r);
        check({tag, ".pulse"}, int'(pulse), p);
        check({tag, ".result"}, int'(result), res);
    endtask

    initial begin
        rst        = 1'b1;
        scene      = 3'b000;
        attack     = 1'b0;
        char_alive = 1'b1;
        mon_alive  = 1'b1;
        pause      = 1'b0;
        #3;
        check_all("reset", 2, 0, 0, 0, 0);

        step();
        rst = 1'b0;
        step();
        check("idle_over", int'(state), 2);

        // Start a battle, then run the full dodge phase into the menu.
        scene = 3'b100;
        step();
        scene = 3'b000;
        check_all("start", 0, 7, 0, 1, 0);
        repeat (7) step();
        check_all("dodge_end", 0, 0, 0, 0, 0);
        step();
        check_all("menu_entry", 1, 4, 0, 1, 0);

        // One-cycle attack ends the menu.
        attack = 1'b1;
        step();
        attack = 1'b0;
        check_all("attack", 0, 7, 1, 1, 0);

        // Pause mid-dodge at time 3; attack during dodge is ignored.
        attack = 1'b1;
        repeat (4) step();
        attack = 1'b0;
        check("dodge_t3", int'(time_left), 3);
        pause = 1'b1;
        repeat (10) step();
        check_all("paused", 0, 3, 1, 0, 0);
        pause = 1'b0;
        repeat (3) step();
        check("resume_t0", int'(time_left), 0);
        step();
        check_all("resume_menu", 1, 4, 1, 1, 0);

        // Attack while paused in menu is ignored; timeout then forfeits the turn.
        pause  = 1'b1;
        attack = 1'b1;
        step();
        pause  = 1'b0;
        attack = 1'b0;
        check_all("menu_pause_atk", 1, 4, 1, 0, 0);
        repeat (4) step();
        check("menu_t0", int'(time_left), 0);
        step();
        check_all("menu_timeout", 0, 7, 2, 1, 0);

        // Monster dies during dodge while paused.
        step();
        pause     = 1'b1;
        mon_alive = 1'b0;
        step();
        check("mon_die.state", int'(state), 2);
        check("mon_die.result", int'(result), 1);
        check("mon_die.pulse", int'(pulse), 1);
        check("mon_die.round", int'(round), 2);
        pause     = 1'b0;
        mon_alive = 1'b1;
        attack    = 1'b1;
        step();
        attack    = 1'b0;
        check("over_hold.state", int'(state), 2);
        check("over_hold.pulse", int'(pulse), 0);

        // Restart clears round and result.
        scene = 3'b100;
        step();
        scene = 3'b000;
        check_all("restart1", 0, 7, 0, 1, 0);

        // Both die together: player counts as lost.
        char_alive = 1'b0;
        mon_alive  = 1'b0;
        step();
        check("both_die.state", int'(state), 2);
        check("both_die.result", int'(result), 2);

        // Start request refused while the character is dead, even with pause.
        mon_alive = 1'b1;
        scene     = 3'b100;
        pause     = 1'b1;
        repeat (2) step();
        check("dead_start.state", int'(state), 2);
        check("dead_start.pulse", int'(pulse), 0);
        check("dead_start.result", int'(result), 2);
        char_alive = 1'b1;
        step();
        pause = 1'b0;
        scene = 3'b000;
        check_all("restart2", 0, 7, 0, 1, 0);

        // Five menu->dodge turns: round saturates at 3.
        for (int i = 0; i < 5; i++) begin
            wait_state(1, "sat_menu");
            attack = 1'b1;
            step();
            attack = 1'b0;
            check($sformatf("sat_round%0d", i), int'(round), (i + 1 > 3) ? 3 : i + 1);
        end

        // End the battle and restart: round and result cleared.
        mon_alive = 1'b0;
        step();
        mon_alive = 1'b1;
        check("sat_over.round", int'(round), 3);
        check("sat_over.result", int'(result), 1);
        scene = 3'b100;
        step();
        scene = 3'b000;
        check_all("restart3", 0, 7, 0, 1, 0);

        // Asynchronous reset mid-menu, observed before the next clock edge.
        attack = 1'b1;
        wait_state(1, "pre_reset_menu");
        step();
        attack = 1'b0;
        wait_state(1, "reset_menu");
        step();
        check("reset_menu_time", int'(time_left), 3);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", 2, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        repeat (2) step();
        check("post_reset.state", int'(state), 2);
        check("post_reset.pulse", int'(pulse), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
